// File: rtl/move_drain_unit.sv
// Drains the eight column move FIFOs in ascending column order and unpacks each packed word into single moves.
// Optional MOVE_STATS_EN adds saturating capture/promotion counters.
module move_drain_unit #(
  parameter int NCOL  = 8,
  parameter int SLOTS = 8,
  parameter int CNTW  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [NCOL-1:0]             i_col_done,
  input  logic [NCOL-1:0]             i_col_empty,
  input  logic [NCOL*SLOTS*19-1:0]    i_col_data,
  output logic [NCOL-1:0]             o_col_rden,
  output logic                        o_mv_valid,
  input  logic                        i_mv_ready,
  output logic [18:0]                 o_mv_data,
  output logic [CNTW-1:0]             o_mv_count,
  output logic                        o_busy,
  output logic                        o_all_done
`ifdef MOVE_STATS_EN
  ,
  output logic [CNTW-1:0]             o_cap_count,
  output logic [CNTW-1:0]             o_promo_count
`endif
);

  localparam int MW = 19;
  localparam int WW = SLOTS * MW;
  localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int SW = $clog2(SLOTS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITC, S_SEL, S_RD, S_LAT, S_UNPK, S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_col_ptr;
  logic [SW-1:0]   r_slot_ptr;
  logic [WW-1:0]   r_buf;
  logic            r_mv_valid;
  logic [MW-1:0]   r_mv_data;
  logic [CNTW-1:0] r_mv_count;

  logic            w_found;
  logic [SW-1:0]   w_idx;
  logic [MW-1:0]   w_slot;
  logic            w_out_free;
  logic            w_hs;
  logic            w_sel_empty;
  logic            w_last_col;

  assign w_out_free  = ~r_mv_valid | i_mv_ready;
  assign w_hs        = r_mv_valid & i_mv_ready;
  assign w_sel_empty = i_col_empty[r_col_ptr];
  assign w_last_col  = (r_col_ptr == PW'(NCOL - 1));

  // Lowest valid slot at or above slot_ptr; invalid slots are skipped without a handshake.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if ((SW'(k) >= r_slot_ptr) && !r_buf[k*MW + MW - 1]) begin
        w_found = 1'b1;
        w_idx   = SW'(k);
      end
    end
  end

  assign w_slot = r_buf[w_idx*MW +: MW];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_WAITC;
      S_WAITC: if (&i_col_done) w_state_next = S_SEL;
      S_SEL: begin
        if (!w_sel_empty)    w_state_next = S_RD;
        else if (w_last_col) w_state_next = S_FIN;
      end
      S_RD:    w_state_next = w_sel_empty ? S_SEL : S_LAT;
      S_LAT:   w_state_next = S_UNPK;
      S_UNPK:  if (w_out_free && !w_found) w_state_next = S_SEL;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCOL; gi++) begin : g_rden
      assign o_col_rden[gi] = (r_state == S_RD) && (r_col_ptr == PW'(gi)) && !i_col_empty[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_col_ptr  <= '0;
      r_slot_ptr <= '0;
      r_buf      <= '0;
      r_mv_valid <= 1'b0;
      r_mv_data  <= '0;
      r_mv_count <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: if (i_start) r_mv_count <= '0;
        S_SEL:  if (w_sel_empty && !w_last_col) r_col_ptr <= r_col_ptr + PW'(1);
        S_LAT: begin
          r_buf      <= i_col_data[r_col_ptr*WW +: WW];
          r_slot_ptr <= '0;
        end
        S_UNPK: begin
          if (w_out_free) begin
            if (w_found) begin
              r_mv_valid <= 1'b1;
              r_mv_data  <= w_slot;
              r_slot_ptr <= w_idx + SW'(1);
            end else begin
              r_mv_valid <= 1'b0;
            end
          end
        end
        S_FIN:  r_col_ptr <= '0;
        default: ;
      endcase
      if (w_hs && (r_mv_count != '1)) r_mv_count <= r_mv_count + CNTW'(1);
    end
  end

`ifdef MOVE_STATS_EN
  logic [CNTW-1:0] r_cap_count;
  logic [CNTW-1:0] r_promo_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cap_count   <= '0;
      r_promo_count <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_cap_count   <= '0;
      r_promo_count <= '0;
    end else if (w_hs) begin
      if (r_mv_data[12] && (r_cap_count != '1))   r_cap_count   <= r_cap_count + CNTW'(1);
      if (r_mv_data[17] && (r_promo_count != '1)) r_promo_count <= r_promo_count + CNTW'(1);
    end
  end

  assign o_cap_count   = r_cap_count;
  assign o_promo_count = r_promo_count;
`endif

  assign o_mv_valid = r_mv_valid;
  assign o_mv_data  = r_mv_data;
  assign o_mv_count = r_mv_count;
  assign o_busy     = (r_state != S_IDLE);
  assign o_all_done = (r_state == S_FIN);

endmodule

// File: tb/tb_move_drain_unit.sv
// Bench for move_drain_unit: FIFO models per column, an ordered expected-move queue built from FIFO contents,
// and a per-cycle compare process; define MOVE_STATS_EN to also exercise the statistics counters.
module tb_move_drain_unit;
  localparam int NCOL = 8, SLOTS = 8, CNTW = 8, MW = 19, WW = SLOTS * MW, DEPTH = 64;
  localparam logic [18:0] INV = 19'h40000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 i_start, i_mv_ready;
  logic [NCOL-1:0]      col_done, col_empty, o_col_rden;
  logic [NCOL*WW-1:0]   col_data;
  logic                 o_mv_valid, o_busy, o_all_done;
  logic [18:0]          o_mv_data;
  logic [CNTW-1:0]      o_mv_count;
`ifdef MOVE_STATS_EN
  logic [CNTW-1:0]      o_cap_count, o_promo_count;
`endif

  move_drain_unit #(.NCOL(NCOL), .SLOTS(SLOTS), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_col_done(col_done),
    .i_col_empty(col_empty), .i_col_data(col_data), .o_col_rden(o_col_rden),
    .o_mv_valid(o_mv_valid), .i_mv_ready(i_mv_ready), .o_mv_data(o_mv_data),
    .o_mv_count(o_mv_count), .o_busy(o_busy), .o_all_done(o_all_done)
`ifdef MOVE_STATS_EN
    , .o_cap_count(o_cap_count), .o_promo_count(o_promo_count)
`endif
  );

  int vec = 0, errs = 0;
  logic [18:0] exp_q[$];
  logic [18:0] got_log[$];
  int rden_pulses = 0;
  logic [7:0] last_rden = '0;

  // Column FIFO models: one-cycle read latency, q held between reads.
  logic [WW-1:0] mem [NCOL][DEPTH];
  int head [NCOL] = '{default: 0};
  int tail [NCOL] = '{default: 0};
  logic [WW-1:0] q [NCOL] = '{default: '0};

  always @(posedge clk) begin
    for (int c = 0; c < NCOL; c++) begin
      if (o_col_rden[c] && head[c] != tail[c]) begin
        q[c]    <= mem[c][head[c] % DEPTH];
        head[c] <= head[c] + 1;
      end
    end
  end

  always_comb begin
    col_data  = '0;
    col_empty = '0;
    for (int c = 0; c < NCOL; c++) begin
      col_data[c*WW +: WW] = q[c];
      col_empty[c]         = (head[c] == tail[c]);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  logic prev_stall = 1'b0;
  logic [18:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(o_mv_valid), 64'd1);
        chk("hold_data", 64'(o_mv_data), 64'(prev_data));
      end
      if (o_mv_valid && i_mv_ready) begin
        if (exp_q.size() == 0) begin
          vec++; errs++;
          $display("FAIL extra_move: got %0h, expected no move", o_mv_data);
        end else begin
          chk("move", 64'(o_mv_data), 64'(exp_q.pop_front()));
        end
        $display("move %0d: %05h count=%0d", got_log.size(), o_mv_data, o_mv_count);
        got_log.push_back(o_mv_data);
      end
      if (o_col_rden != '0) begin
        rden_pulses++;
        last_rden = o_col_rden;
        chk("rden_onehot", 64'($onehot(o_col_rden)), 64'd1);
        chk("rden_nonempty", 64'(o_col_rden & col_empty), 64'd0);
      end
      prev_stall = o_mv_valid && !i_mv_ready;
      prev_data  = o_mv_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input int c, input logic [WW-1:0] w);
    mem[c][tail[c] % DEPTH] = w;
    tail[c]++;
  endtask

  function automatic logic [WW-1:0] mk_word(input logic [18:0] base, input int nvalid);
    logic [WW-1:0] w;
    for (int k = 0; k < SLOTS; k++) w[k*MW +: MW] = (k < nvalid) ? base + 19'(k) : INV;
    return w;
  endfunction

  // Expected stream: columns ascending, words in FIFO order, valid slots in slot order.
  task automatic build_expected();
    logic [WW-1:0] w;
    exp_q.delete();
    for (int c = 0; c < NCOL; c++)
      for (int i = head[c]; i < tail[c]; i++) begin
        w = mem[c][i % DEPTH];
        for (int k = 0; k < SLOTS; k++)
          if (!w[k*MW + MW - 1]) exp_q.push_back(w[k*MW +: MW]);
      end
  endtask

  task automatic run_pass(input bit mid_start, output int cycles);
    int total;
    got_log.delete();
    rden_pulses = 0;
    build_expected();
    total = exp_q.size();
    i_start = 1'b1; tick(); i_start = 1'b0;
    cycles = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (o_all_done) begin cycles = n; break; end
      @(posedge clk); #1;
      i_start = mid_start && (n == 30);
    end
    i_start = 1'b0;
    if (cycles < 0) begin
      vec++; errs++;
      $display("FAIL pass_timeout: all_done not seen, expected within 3000 cycles");
    end
    chk("mv_count", 64'(o_mv_count), 64'((total > 255) ? 255 : total));
    chk("moves_left", 64'(exp_q.size()), 64'd0);
    $display("pass: %0d moves expected, %0d seen, mv_count=%0d", total, got_log.size(), o_mv_count);
    tick();
  endtask

  int cyc, n;
  logic [WW-1:0] w;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_mv_ready = 1'b1; col_done = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", 64'(o_col_rden), 0);
    chk("rst_valid", 64'(o_mv_valid), 0);
    chk("rst_data", 64'(o_mv_data), 0);
    chk("rst_count", 64'(o_mv_count), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_all_done), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Reset mid-unpack.
    push_word(3, mk_word(19'h00123, 3));
    build_expected();
    col_done = 8'hFF;
    i_start = 1'b1; tick(); i_start = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin @(negedge clk); if (o_mv_valid) begin n = 1; break; end end
    chk("t1_valid_seen", 64'(n), 1);
    @(posedge clk); #1; i_mv_ready = 1'b0;
    @(negedge clk);
    chk("t1_pre_count", 64'(o_mv_count), 1);
    chk("t1_pre_valid", 64'(o_mv_valid), 1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("t1_valid", 64'(o_mv_valid), 0);
    chk("t1_busy", 64'(o_busy), 0);
    chk("t1_rden", 64'(o_col_rden), 0);
    chk("t1_count", 64'(o_mv_count), 0);
    tick(); rst = 1'b0;
    for (int c = 0; c < NCOL; c++) tail[c] = head[c];
    exp_q.delete();
    i_mv_ready = 1'b1;
    tick();

    // Not all columns done: must wait; then empty pass.
    col_done = 8'h7F;
    i_start = 1'b1; tick(); i_start = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("t2_busy", 64'(o_busy), 1);
    chk("t2_rden", 64'(o_col_rden), 0);
    chk("t2_done", 64'(o_all_done), 0);
    @(posedge clk); #1; col_done = 8'hFF;
    cyc = -1;
    for (int k = 1; k <= 50; k++) begin @(negedge clk); if (o_all_done) begin cyc = k; break; end end
    chk("t2_latency", 64'(cyc), 64'd10);
    chk("t2_count", 64'(o_mv_count), 0);
    @(negedge clk);
    chk("t2_pulse", 64'(o_all_done), 0);
    tick();

    // Column 3, slots 0 and 2 valid.
    w = {SLOTS{INV}};
    w[0*MW +: MW] = {7'b0, 6'o14, 6'o34};
    w[2*MW +: MW] = {7'b0, 6'o14, 6'o24};
    push_word(3, w);
    run_pass(1'b0, cyc);
    chk("t3_nmoves", 64'(got_log.size()), 2);
    chk("t3_move0", 64'(got_log[0]), 64'h0031C);
    chk("t3_move1", 64'(got_log[1]), 64'h00314);
    chk("t3_rden_pulses", 64'(rden_pulses), 1);
    chk("t3_rden", 64'(last_rden), 64'h08);

    // Same word with mv_ready low for 5 cycles.
    push_word(3, w);
    i_mv_ready = 1'b0;
    fork
      run_pass(1'b0, cyc);
      begin
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (o_mv_valid) break; end
        repeat (5) tick();
        @(negedge clk);
        chk("t4_stall_rden", 64'(rden_pulses), 1);
        chk("t4_stall_count", 64'(o_mv_count), 0);
        chk("t4_stall_data", 64'(o_mv_data), 64'h0031C);
        @(posedge clk); #1; i_mv_ready = 1'b1;
      end
    join
    chk("t4_nmoves", 64'(got_log.size()), 2);
    chk("t4_rden_pulses", 64'(rden_pulses), 1);

    // Columns 0 and 7, two full words each; a start mid-pass is ignored.
    push_word(7, mk_word(19'h00700, 8));
    push_word(7, mk_word(19'h00710, 8));
    push_word(0, mk_word(19'h00010, 8));
    push_word(0, mk_word(19'h00020, 8));
    run_pass(1'b1, cyc);
    chk("t5_nmoves", 64'(got_log.size()), 32);
    chk("t5_first", 64'(got_log[0]), 64'h00010);
    chk("t5_col7_first", 64'(got_log[16]), 64'h00700);
    chk("t5_last", 64'(got_log[31]), 64'h00717);
    chk("t5_count_lit", 64'(o_mv_count), 32);

    // 300 moves: counter saturates.
    for (int i = 0; i < 19; i++) push_word(2, mk_word(19'h01000 + 19'(8*i), 8));
    for (int i = 0; i < 19; i++) push_word(5, mk_word(19'h02000 + 19'(8*i), (i == 18) ? 4 : 8));
    run_pass(1'b0, cyc);
    chk("t5b_nmoves", 64'(got_log.size()), 300);
    chk("t5b_count_lit", 64'(o_mv_count), 255);

`ifdef MOVE_STATS_EN
    w = {SLOTS{INV}};
    w[0*MW +: MW] = 19'h01000;
    w[1*MW +: MW] = 19'h21000;
    w[2*MW +: MW] = 19'h00041;
    push_word(4, w);
    run_pass(1'b0, cyc);
    chk("t6_cap", 64'(o_cap_count), 2);
    chk("t6_promo", 64'(o_promo_count), 1);
    run_pass(1'b0, cyc);
    chk("t6_cap_clr", 64'(o_cap_count), 0);
    chk("t6_promo_clr", 64'(o_promo_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
